// File: rtl/dlfloat16_pkg.sv
// rtl/dlfloat16_pkg.sv - DLFloat16 shared constants, exception bit indices and exception vector type
package dlfloat16_pkg;

  localparam int FP_W  = 16;
  localparam int EXC_W = 5;

  // Exception vector bit positions: {invalid, inexact, overflow, underflow, div_zero}
  localparam int EXC_INVALID   = 4;
  localparam int EXC_INEXACT   = 3;
  localparam int EXC_OVERFLOW  = 2;
  localparam int EXC_UNDERFLOW = 1;
  localparam int EXC_DIV_ZERO  = 0;

  typedef logic [FP_W-1:0]  fp_t;
  typedef logic [EXC_W-1:0] exc_t;

endpackage

// File: rtl/dlfloat16_sync_fifo.sv
// rtl/dlfloat16_sync_fifo.sv - single-clock FIFO storage with occupancy count and unregistered head read
module dlfloat16_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));

endmodule

// File: rtl/dlfloat16_wb_queue.sv
// rtl/dlfloat16_wb_queue.sv - DLFloat16 result write-back queue with sticky fflags; DLFLOAT16_WB_BYPASS_EN enables empty-queue bypass
module dlfloat16_wb_queue
  import dlfloat16_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [FP_W-1:0]         in_data,
  input  logic [EXC_W-1:0]        in_exc,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [FP_W-1:0]         out_data,
  output logic [EXC_W-1:0]        out_exc,
  output logic [TAG_W-1:0]        out_tag,
  output logic [EXC_W-1:0]        fflags,
  input  logic                    fflags_wr,
  input  logic [EXC_W-1:0]        fflags_wdata,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    drop_err
);

  localparam int EW = FP_W + EXC_W + TAG_W;

  logic [EW-1:0] fifo_wdata;
  logic [EW-1:0] fifo_rdata;
  logic          fifo_wr;
  logic          fifo_rd;
  logic          fifo_empty;
  logic          fifo_full;
  logic          in_fire;
  logic          out_fire;
  logic          bypass;
  exc_t          fflags_q;
  logic          drop_q;

  assign fifo_wdata = {in_data, in_exc, in_tag};

`ifdef DLFLOAT16_WB_BYPASS_EN
  assign bypass   = fifo_empty & in_valid;
  assign in_ready = ~fifo_full | out_ready;
`else
  assign bypass   = 1'b0;
  assign in_ready = ~fifo_full;
`endif

  assign out_valid = ~fifo_empty | bypass;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // A bypassed entry that retires in the same cycle never touches storage.
  assign fifo_wr = in_fire & ~(bypass & out_ready);
  assign fifo_rd = out_fire & ~fifo_empty;

  always_comb begin
    out_data = '0;
    out_exc  = '0;
    out_tag  = '0;
`ifdef DLFLOAT16_WB_BYPASS_EN
    if (bypass) begin
      out_data = in_data;
      out_exc  = in_exc;
      out_tag  = in_tag;
    end else if (!fifo_empty) begin
      {out_data, out_exc, out_tag} = fifo_rdata;
    end
`else
    if (!fifo_empty) begin
      {out_data, out_exc, out_tag} = fifo_rdata;
    end
`endif
  end

  dlfloat16_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (fifo_wr),
    .wr_data (fifo_wdata),
    .rd_en   (fifo_rd),
    .rd_data (fifo_rdata),
    .count   (count),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  // The retiring exception is ORed after the CSR write so it is never overwritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fflags_q <= '0;
      drop_q   <= 1'b0;
    end else begin
      fflags_q <= (fflags_wr ? fflags_wdata : fflags_q) | (out_fire ? out_exc : '0);
      drop_q   <= (in_valid & ~in_ready) | (drop_q & ~fflags_wr);
    end
  end

  assign fflags   = fflags_q;
  assign drop_err = drop_q;

endmodule

// File: tb/tb_dlfloat16_wb_queue.sv
// tb/tb_dlfloat16_wb_queue.sv - randomized and directed self-checking bench for dlfloat16_wb_queue
module tb_dlfloat16_wb_queue;

  localparam int DEPTH = 4;
  localparam int TAG_W = 5;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef DLFLOAT16_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_data;
  logic [4:0]       in_exc;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_data;
  logic [4:0]       out_exc;
  logic [TAG_W-1:0] out_tag;
  logic [4:0]       fflags;
  logic             fflags_wr;
  logic [4:0]       fflags_wdata;
  logic [CW-1:0]    count;
  logic             drop_err;

  dlfloat16_wb_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_exc       (in_exc),
    .in_tag       (in_tag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_exc      (out_exc),
    .out_tag      (out_tag),
    .fflags       (fflags),
    .fflags_wr    (fflags_wr),
    .fflags_wdata (fflags_wdata),
    .count        (count),
    .drop_err     (drop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of entries plus sticky flag state.
  typedef struct packed {
    logic [15:0]      d;
    logic [4:0]       e;
    logic [TAG_W-1:0] t;
  } ent_t;

  ent_t       mq[$];
  logic [4:0] m_fflags;
  logic       m_drop;
  bit         model_on = 1'b0;

  always @(negedge clk) begin : compare
    bit   full, rdy, byp, ov, inf, outf;
    ent_t head;
    if (model_on) begin
      #2;
      full = (mq.size() == DEPTH);
      rdy  = !full || (BYP && out_ready);
      byp  = BYP && (mq.size() == 0) && in_valid;
      ov   = (mq.size() != 0) || byp;
      head = '0;
      if (byp) head = {in_data, in_exc, in_tag};
      else if (mq.size() != 0) head = mq[0];
      chk("m_in_ready", in_ready, rdy);
      chk("m_out_valid", out_valid, ov);
      chk("m_out_data", out_data, head.d);
      chk("m_out_exc", out_exc, head.e);
      chk("m_out_tag", out_tag, head.t);
      chk("m_count", count, mq.size());
      chk("m_fflags", fflags, m_fflags);
      chk("m_drop_err", drop_err, m_drop);
      inf  = in_valid && rdy;
      outf = ov && out_ready;
      if (outf && mq.size() != 0) void'(mq.pop_front());
      if (inf && !(byp && outf)) mq.push_back({in_data, in_exc, in_tag});
      m_fflags = (fflags_wr ? fflags_wdata : m_fflags) | (outf ? head.e : 5'b0);
      m_drop   = (in_valid && !rdy) || (m_drop && !fflags_wr);
    end
  end

  task automatic model_reset();
    mq.delete();
    m_fflags = '0;
    m_drop   = 1'b0;
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic [4:0] e,
                       input logic [TAG_W-1:0] t, input logic ordy);
    in_valid  = v;
    in_data   = d;
    in_exc    = e;
    in_tag    = t;
    out_ready = ordy;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 16'h0, 5'h0, '0, 1'b0);
    fflags_wr    = 1'b0;
    fflags_wdata = '0;
    repeat (2) @(negedge clk);
    #3;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_count", count, 0);
    chk("rst_fflags", fflags, 5'b0);
    chk("rst_drop_err", drop_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    model_on = 1'b1;

    // Single push then retire; flags land one cycle after retirement.
    @(negedge clk);
    drive(1'b1, 16'h3C00, 5'b00010, 5'd3, 1'b1);
`ifdef DLFLOAT16_WB_BYPASS_EN
    #3;
    chk("byp_out_valid", out_valid, 1'b1);
    chk("byp_out_data", out_data, 16'h3C00);
`endif
    @(negedge clk);
    drive(1'b0, 16'h0, 5'h0, '0, 1'b1);
`ifndef DLFLOAT16_WB_BYPASS_EN
    #3;
    chk("p1_out_valid", out_valid, 1'b1);
    chk("p1_out_data", out_data, 16'h3C00);
    chk("p1_out_tag", out_tag, 5'd3);
`endif
    @(negedge clk);
    #3;
    chk("p1_fflags", fflags, 5'b00010);

    // Overflow: fill, then a fifth push is dropped and never emerges.
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      drive(1'b1, 16'hA000 + 16'(i), 5'h0, 5'(i), 1'b0);
    end
    @(negedge clk);
    drive(1'b1, 16'hDEAD, 5'h0, 5'd31, 1'b0);
    #3;
    chk("ovf_in_ready", in_ready, 1'b0);
    chk("ovf_count", count, DEPTH);
    @(negedge clk);
    drive(1'b0, 16'h0, 5'h0, '0, 1'b1);
    #3;
    chk("ovf_drop_err", drop_err, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      chk("ovf_drain_data", out_data, 16'hA000 + 16'(i));
      @(negedge clk);
      #3;
    end
    chk("ovf_empty_after", out_valid, 1'b0);

    // Steady push/pop below full across several pointer wraps.
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'hB000 + 16'(i), 5'h0, 5'(i), 1'b0);
      @(negedge clk);
    end
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 16'hB003 + 16'(k), 5'h0, 5'(k), 1'b1);
      #3;
      chk("wrap_count", count, 3);
      chk("wrap_data", out_data, 16'hB000 + 16'(k));
      @(negedge clk);
    end
    drive(1'b0, 16'h0, 5'h0, '0, 1'b1);
    repeat (4) @(negedge clk);

`ifdef DLFLOAT16_WB_BYPASS_EN
    // Full queue with out_ready high keeps accepting at constant count.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 16'hC000 + 16'(i), 5'h0, 5'(i), 1'b0);
      @(negedge clk);
    end
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 16'hC004 + 16'(k), 5'h0, 5'(k), 1'b1);
      #3;
      chk("fullbyp_in_ready", in_ready, 1'b1);
      chk("fullbyp_count", count, DEPTH);
      chk("fullbyp_data", out_data, 16'hC000 + 16'(k));
      @(negedge clk);
    end
    drive(1'b0, 16'h0, 5'h0, '0, 1'b1);
    repeat (5) @(negedge clk);
    drive(1'b1, 16'hFFFF, 5'h0, 5'd1, 1'b1);
    #3;
    chk("byp_ffff_valid", out_valid, 1'b1);
    chk("byp_ffff_data", out_data, 16'hFFFF);
    chk("byp_ffff_count", count, 0);
    @(negedge clk);
    drive(1'b0, 16'h0, 5'h0, '0, 1'b0);
    #3;
    chk("byp_ffff_count_after", count, 0);
    @(negedge clk);
`endif

    // CSR write and retiring exception in the same cycle.
    drive(1'b0, 16'h0, 5'h0, '0, 1'b0);
    fflags_wr = 1'b1; fflags_wdata = 5'b00001;
    @(negedge clk);
    fflags_wr = 1'b0;
    drive(1'b1, 16'h4000, 5'b01000, 5'd7, 1'b0);
    #3;
    chk("csr_fflags_set", fflags, 5'b00001);
    @(negedge clk);
    drive(1'b0, 16'h0, 5'h0, '0, 1'b1);
    fflags_wr = 1'b1; fflags_wdata = 5'b00000;
    @(negedge clk);
    fflags_wr = 1'b0;
    #3;
    chk("csr_retire_fflags", fflags, 5'b01000);

    // Asynchronous reset mid-cycle with entries queued.
    @(negedge clk);
    drive(1'b0, 16'h0, 5'h0, '0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b1, 16'hE000 + 16'(i), 5'b00100, 5'(i), 1'b0);
    end
    @(negedge clk);
    drive(1'b0, 16'h0, 5'h0, '0, 1'b0);
    #3;
    chk("prereset_count", count, 3);
    model_on = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", out_valid, 1'b0);
    chk("async_count", count, 0);
    chk("async_fflags", fflags, 5'b0);
    chk("async_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    model_on = 1'b1;

    // Randomized traffic: a fill-biased phase then a drain-biased phase.
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      drive($urandom_range(0, 99) < 60, 16'($urandom), 5'($urandom), TAG_W'($urandom),
            $urandom_range(0, 99) < ((c < 300) ? 30 : 80));
      fflags_wr    = ($urandom_range(0, 99) < 5);
      fflags_wdata = 5'($urandom);
    end
    @(negedge clk);
    drive(1'b0, 16'h0, 5'h0, '0, 1'b1);
    fflags_wr = 1'b0;
    repeat (DEPTH + 2) @(negedge clk);
    model_on = 1'b0;
    #4;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
